// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two core ports, the arbiter and the word memory.
// The core side drives requests; the arbiter side drives grants and memory strobes.
interface mem_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 10
);
    logic                      instr_req;
    logic                      instr_gnt;
    logic                      instr_rvalid;
    logic [31:0]               instr_addr;
    logic [31:0]               instr_rdata;
    logic                      instr_err;
    logic                      data_req;
    logic                      data_gnt;
    logic                      data_rvalid;
    logic                      data_we;
    logic [3:0]                data_be;
    logic [31:0]               data_addr;
    logic [31:0]               data_wdata;
    logic [31:0]               data_rdata;
    logic                      data_err;
    logic                      mem_en;
    logic                      mem_we;
    logic [3:0]                mem_be;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_wdata;
    logic [31:0]               mem_rdata;

    modport master (
        output instr_req, instr_addr,
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  instr_req, instr_addr,
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle word memory
// between the instruction and data ports of the core.
module mem_arbiter #(
    parameter int MEM_SIZE       = 4096,
    parameter int MEM_ADDR_WIDTH = $clog2(MEM_SIZE / 4)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    input  logic [31:0]               instr_addr_i,
    output logic [31:0]               instr_rdata_o,
    output logic                      instr_err_o,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_addr_i,
    input  logic [31:0]               data_wdata_i,
    output logic [31:0]               data_rdata_o,
    output logic                      data_err_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i
);

    typedef struct packed {
        logic owner;
        logic valid;
        logic err;
        logic ok;
        logic we;
    } resp_t;

    logic        last_q, last_d;
    resp_t       resp_q, resp_d;
    logic        gnt_i, gnt_d, any_gnt;
    logic        in_range;
    logic [31:0] sel_addr;
    logic [31:0] rd_data;

    // last_q = 1 means data was granted last, so instr wins the next conflict
    always_comb begin
        gnt_d    = data_req_i & (~instr_req_i | ~last_q);
        gnt_i    = instr_req_i & ~gnt_d;
        any_gnt  = gnt_i | gnt_d;
        sel_addr = gnt_d ? data_addr_i : instr_addr_i;
        in_range = sel_addr < 32'(MEM_SIZE);
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (any_gnt) begin
            mem_en_o    = in_range;
            mem_we_o    = gnt_d & data_we_i & in_range;
            mem_be_o    = gnt_d ? data_be_i : 4'hF;
            mem_addr_o  = sel_addr[MEM_ADDR_WIDTH+1:2];
            mem_wdata_o = gnt_d ? data_wdata_i : 32'h0;
        end
    end

    always_comb begin
        last_d = any_gnt ? gnt_d : last_q;
        resp_d = '0;
        if (any_gnt) begin
            resp_d.owner = gnt_d;
            resp_d.valid = 1'b1;
            resp_d.err   = ~in_range;
            resp_d.ok    = in_range;
            resp_d.we    = gnt_d & data_we_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
            resp_q <= '0;
        end else begin
            last_q <= last_d;
            resp_q <= resp_d;
        end
    end

    // Writes and out-of-range accesses return zero data
    always_comb begin
        rd_data = 32'h0;
        if (resp_q.valid && resp_q.ok && !resp_q.we)
            rd_data = mem_rdata_i;
    end

    assign instr_gnt_o    = gnt_i;
    assign data_gnt_o     = gnt_d;
    assign instr_rvalid_o = resp_q.valid & ~resp_q.owner;
    assign data_rvalid_o  = resp_q.valid & resp_q.owner;
    assign instr_err_o    = resp_q.valid & ~resp_q.owner & resp_q.err;
    assign data_err_o     = resp_q.valid & resp_q.owner & resp_q.err;
    assign instr_rdata_o  = resp_q.owner ? 32'h0 : rd_data;
    assign data_rdata_o   = resp_q.owner ? rd_data : 32'h0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares one single-port, 1-cycle-latency word memory between the core instruction port and data port. It uses the same req/gnt/rvalid handshake as the core memory interface and replaces a dual-port array where only a single-port macro is available. Simultaneous requests are resolved round-robin. Read data and rvalid are returned to the master that owned the access. Out-of-range accesses complete with an error flag.

## Interface
- MEM_SIZE, 4096: memory size in bytes; power of two, ≥ 8.
- MEM_ADDR_WIDTH, $clog2(MEM_SIZE/4): word-address width to the memory (derived).
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  instruction request.
- instr_gnt_o  out  1  instruction grant (combinational).
- instr_rvalid_o  out  1  instruction response valid.
- instr_addr_i  in  32  instruction byte address.
- instr_rdata_o  out  32  instruction read data.
- instr_err_o  out  1  instruction response error (out of range).
- data_req_i  in  1  data request.
- data_gnt_o  out  1  data grant (combinational).
- data_rvalid_o  out  1  data response valid.
- data_we_i  in  1  data write enable.
- data_be_i  in  4  data byte enables.
- data_addr_i  in  32  data byte address.
- data_wdata_i  in  32  data write data.
- data_rdata_o  out  32  data read data.
- data_err_o  out  1  data response error.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  MEM_ADDR_WIDTH  memory word address, taken from addr[MEM_ADDR_WIDTH+1:2].
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid one cycle after mem_en_o.

## Operation
- State: last_q (0 = instr was last granted, 1 = data) and resp_q (owner, valid, err, range-ok) for the single in-flight response.
- Grant is combinational and at most one grant is asserted per cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master that was not last granted.
- On any grant, last_q is updated to the granted master.
- Range check: in range iff addr[31:0] < MEM_SIZE.
- In-range grant: mem_en_o = 1.
  - mem_we_o and mem_be_o come from the data port when data is granted.
  - When instr is granted, mem_we_o = 0 and mem_be_o = 4'hF.
- Out-of-range grant: mem_en_o = 0, but the grant is still given. The response carries err = 1 and rdata = 0.
- Address alignment: addr[1:0] is ignored.
- No grant: mem_en_o = 0. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are 0.
- Response routing:
  - resp_q.valid is set on any grant and cleared otherwise.
  - The owner's rvalid equals resp_q.valid for that owner; the other master's rvalid is 0.
  - Writes also receive an rvalid, with rdata = 0.
- Read data:
  - The owner's rdata is mem_rdata_i when the response is in range and was a read; otherwise 0.
  - The non-owner's rdata is 0.
  - rdata is only meaningful while rvalid = 1.
- A new grant is allowed in the same cycle as a pending response (fully pipelined, one access per cycle).
- Requesters must hold req and payload stable until gnt; the arbiter does not buffer requests.

## Timing
- Reset values (asynchronous, immediate): last_q = 1, so instr wins the first conflict. resp_q cleared. All rvalid, err and rdata outputs are 0.
- Grant latency: 0 cycles (same-cycle gnt). Response latency: exactly 1 cycle after gnt.
- Throughput: 1 access per cycle total.
- With both masters continuously requesting, grants strictly alternate and each master waits at most 1 cycle.
- Reset mid-access: the pending rvalid is dropped and is not emitted after reset release.
- A req that is withdrawn before gnt is protocol-illegal; the arbiter re-evaluates it every cycle regardless.
- No combinational path from mem_rdata_i to any gnt output.

## Test plan
- Reset then a single instr read at addr 0x10, with memory word 4 = 0xDEADBEEF:
  - gnt in the same cycle; mem_addr_o = 4.
  - Next cycle: instr_rvalid_o = 1, instr_rdata_o = 0xDEADBEEF, data_rvalid_o = 0.
- Both masters request on the first cycle after reset:
  - instr granted first, data the next cycle.
  - With both held high for 6 cycles, the grant sequence is I,D,I,D,I,D.
- Data write 0x12345678, be = 4'b0011, addr 0x20, then data read of 0x20, with old word 0xAAAAAAAA:
  - Write rvalid arrives with rdata = 0.
  - Read returns 0xAAAA5678.
- Data read at addr 0x1000 (MEM_SIZE 4096):
  - gnt = 1 and mem_en_o = 0.
  - Next cycle: data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
- Back-to-back instr reads at 0x0 and 0x4 on consecutive cycles: rvalid high on two consecutive cycles with the matching data, with no bubble.
- Assert rst_i in the cycle after a grant: rvalid stays 0, and after release the next conflict grants instr.
